// File: rtl/vga_stream_pkg.sv
// Shared types and constants for the VGA stream filter: channel widths,
// filter modes, pixel/beat layouts and per-channel arithmetic helpers.
package vga_stream_pkg;

  localparam int CH_W       = 10;
  localparam int PIX_W      = 3 * CH_W;
  localparam int LUMA_W     = CH_W + 2;
  localparam int VGA_WIDTH  = 640;
  localparam int VGA_HEIGHT = 480;

  typedef enum logic [2:0] {
    MODE_PASS    = 3'd0,
    MODE_INVERT  = 3'd1,
    MODE_LIGHTEN = 3'd2,
    MODE_DARKEN  = 3'd3,
    MODE_GREY    = 3'd4,
    MODE_THRESH  = 3'd5
  } filter_mode_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel_t;

  typedef struct packed {
    pixel_t       px;
    logic         sop;
    logic         eop;
    filter_mode_t mode;
  } s1_beat_t;

  typedef struct packed {
    pixel_t px;
    logic   sop;
    logic   eop;
  } s2_beat_t;

  // Codes 6 and 7 are reserved and behave as pass-through.
  function automatic filter_mode_t decode_mode(input logic [2:0] sel);
    filter_mode_t m;
    case (sel)
      3'd1:    m = MODE_INVERT;
      3'd2:    m = MODE_LIGHTEN;
      3'd3:    m = MODE_DARKEN;
      3'd4:    m = MODE_GREY;
      3'd5:    m = MODE_THRESH;
      default: m = MODE_PASS;
    endcase
    return m;
  endfunction

  function automatic logic [CH_W-1:0] lighten_ch(input logic [CH_W-1:0] c);
    logic [LUMA_W-1:0] s;
    s = LUMA_W'(c) + LUMA_W'(c >> 2);
    if (s > LUMA_W'({CH_W{1'b1}})) return {CH_W{1'b1}};
    return s[CH_W-1:0];
  endfunction

  function automatic logic [CH_W-1:0] darken_ch(input logic [CH_W-1:0] c);
    return c - (c >> 2);
  endfunction

endpackage

// File: rtl/vga_filter_pipe_reg.sv
// One elastic pipeline stage: loads payload and valid whenever the stage
// is allowed to advance; payload only changes on a valid load.
module vga_filter_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/vga_stream_filter.sv
// Two-stage Avalon-ST colour filter with per-frame mode latch.
// Define VGA_FILTER_PKT_CHECK_EN to build the sticky framing checker.
module vga_stream_filter
  import vga_stream_pkg::*;
#(
  parameter int              FRAME_PIXELS = VGA_WIDTH * VGA_HEIGHT,
  parameter logic [CH_W-1:0] THRESH       = 10'd512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       filter_select,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pkt_error,
  output logic [2:0]       active_mode
);

  logic         s1_valid, s2_valid, adv2, in_fire;
  filter_mode_t mode_q, mode_d, beat_mode;
  s1_beat_t     s1_in, s1_q;
  s2_beat_t     s2_d, s2_q;
  pixel_t       px_f;
  logic [LUMA_W-1:0] luma_sum;
  logic [CH_W-1:0]   luma;

  assign adv2     = !s2_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign in_fire  = in_valid && in_ready;

  // The mode rides with each beat, so a new SOP never retags older beats.
  assign beat_mode = in_sop ? decode_mode(filter_select) : mode_q;
  assign mode_d    = (in_fire && in_sop) ? beat_mode : mode_q;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_PASS;
    else       mode_q <= mode_d;
  end

  assign s1_in = '{px: pixel_t'(in_data), sop: in_sop, eop: in_eop, mode: beat_mode};

  vga_filter_pipe_reg #(.W($bits(s1_beat_t))) u_s1 (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (in_ready),
    .valid_i (in_valid),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .data_o  (s1_q)
  );

  assign luma_sum = LUMA_W'(s1_q.px.r) + (LUMA_W'(s1_q.px.g) << 1) + LUMA_W'(s1_q.px.b);
  assign luma     = luma_sum[LUMA_W-1:2];

  always_comb begin
    px_f = s1_q.px;
    case (s1_q.mode)
      MODE_INVERT:  px_f = ~s1_q.px;
      MODE_LIGHTEN: px_f = '{r: lighten_ch(s1_q.px.r), g: lighten_ch(s1_q.px.g),
                             b: lighten_ch(s1_q.px.b)};
      MODE_DARKEN:  px_f = '{r: darken_ch(s1_q.px.r), g: darken_ch(s1_q.px.g),
                             b: darken_ch(s1_q.px.b)};
      MODE_GREY:    px_f = '{r: luma, g: luma, b: luma};
      MODE_THRESH:  px_f = (luma >= THRESH) ? '1 : '0;
      default:      px_f = s1_q.px;
    endcase
  end

  assign s2_d = '{px: px_f, sop: s1_q.sop, eop: s1_q.eop};

  vga_filter_pipe_reg #(.W($bits(s2_beat_t))) u_s2 (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (adv2),
    .valid_i (s1_valid),
    .data_i  (s2_d),
    .valid_o (s2_valid),
    .data_o  (s2_q)
  );

  assign out_valid   = s2_valid;
  assign out_data    = s2_q.px;
  assign out_sop     = s2_q.sop;
  assign out_eop     = s2_q.eop;
  assign active_mode = mode_q;

`ifdef VGA_FILTER_PKT_CHECK_EN
  localparam logic [18:0] LAST_IDX = 19'(FRAME_PIXELS - 1);

  logic [18:0] cnt_q, cnt_d, idx;
  logic        seen_q, seen_d, open_q, open_d, err_q, err_d;

  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q;
    open_d = open_q;
    err_d  = err_q;
    idx    = in_sop ? 19'd0 : cnt_q;
    if (in_fire) begin
      if (!in_sop && !seen_q)                 err_d = 1'b1;
      if (in_sop && open_q && cnt_q != 19'd0) err_d = 1'b1;
      if (in_eop != (idx == LAST_IDX))        err_d = 1'b1;
      cnt_d  = idx + 19'd1;
      open_d = !in_eop;
      seen_d = seen_q || in_sop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
      open_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      open_q <= open_d;
      err_q  <= err_d;
    end
  end

  assign pkt_error = err_q;
`else
  assign pkt_error = 1'b0;
`endif

endmodule
